// File: rtl/ahb_lite_wb_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge with byte lanes, optional
// posted writes, a strobe timeout and two-cycle AHB error responses.
module ahb_lite_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int POSTED_WRITES  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [ADDR_WIDTH-1:0]     HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [DATA_WIDTH-1:0]     HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic [DATA_WIDTH-1:0]     HRDATA,
  output logic                      HRESP,
  output logic                      wb_cyc,
  output logic                      wb_stb,
  output logic                      wb_we,
  output logic [ADDR_WIDTH-1:0]     wb_adr,
  output logic [DATA_WIDTH/8-1:0]   wb_sel,
  output logic [DATA_WIDTH-1:0]     wb_dat_w,
  input  logic [DATA_WIDTH-1:0]     wb_dat_r,
  input  logic                      wb_ack,
  input  logic                      wb_err,
  output logic                      posted_err_o,
  input  logic                      posted_err_clr_i
);

  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(SEL_W);
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam bit POSTED = (POSTED_WRITES != 0);

  typedef enum logic [2:0] {IDLE, RD, WLAT, WR, ERR1, ERR2} state_t;

  state_t                  state, state_next;
  logic                    pend_valid, pend_write;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [2:0]              pend_size;
  logic [TW-1:0]           tmo_cnt;
  logic                    hold_cyc;
  logic                    accept, tmo, wb_fail, stb_phase;
  logic                    load_cur, pend_set, perr_set;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [2:0]              src_size;
  logic                    src_write, src_err;
  logic                    unused_bits;

  function automatic logic [SEL_W-1:0] lane_sel(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [2:0] s);
    int off, n;
    lane_sel = '0;
    off = int'(a[LSB-1:0]);
    n   = 1 << s;
    for (int i = 0; i < SEL_W; i++) lane_sel[i] = (i >= off) && (i < off + n);
  endfunction

  function automatic logic dec_err(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] s);
    return (s > 3'(LSB)) || ((int'(a[LSB-1:0]) & ((1 << s) - 1)) != 0);
  endfunction

  function automatic state_t route(input logic err, input logic wr);
    return err ? ERR1 : (wr ? WLAT : RD);
  endfunction

  assign unused_bits = ^{HBURST, HTRANS[0]};
  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign stb_phase   = (state == RD) || (state == WR);
  assign tmo         = (TIMEOUT_CYCLES != 0) && stb_phase && (tmo_cnt == TO_LIMIT);
  assign wb_fail     = wb_err || tmo;

  // A held transfer always takes precedence; it only exists while a posted write is in WR.
  assign src_addr  = pend_valid ? pend_addr  : HADDR;
  assign src_size  = pend_valid ? pend_size  : HSIZE;
  assign src_write = pend_valid ? pend_write : HWRITE;
  assign src_err   = dec_err(src_addr, src_size);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state        <= IDLE;
      pend_valid   <= 1'b0;
      pend_write   <= 1'b0;
      pend_addr    <= '0;
      pend_size    <= '0;
      tmo_cnt      <= '0;
      hold_cyc     <= 1'b0;
      HRDATA       <= '0;
      wb_adr       <= '0;
      wb_sel       <= '0;
      wb_dat_w     <= '0;
      posted_err_o <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cyc <= (state == WR) && (state_next == WLAT);
      tmo_cnt  <= (stb_phase && !tmo && !wb_ack && !wb_err) ? tmo_cnt + 1'b1 : '0;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_addr  <= HADDR;
        pend_size  <= HSIZE;
        pend_write <= HWRITE;
      end else if (load_cur) begin
        pend_valid <= 1'b0;
      end
      if (load_cur && !src_err) begin
        wb_adr <= {src_addr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
        wb_sel <= lane_sel(src_addr, src_size);
      end
      if (state == WLAT) wb_dat_w <= HWDATA;
      if (state == RD && wb_ack && !wb_fail) HRDATA <= wb_dat_r;
      if (perr_set) posted_err_o <= 1'b1;
      else if (posted_err_clr_i) posted_err_o <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    load_cur   = 1'b0;
    pend_set   = 1'b0;
    perr_set   = 1'b0;
    case (state)
      IDLE, ERR2: begin
        state_next = IDLE;
        if (accept) begin
          load_cur   = 1'b1;
          state_next = route(src_err, src_write);
        end
      end
      RD: begin
        if (wb_fail) state_next = ERR1;
        else if (wb_ack) state_next = IDLE;
      end
      WLAT: begin
        state_next = WR;
        pend_set   = POSTED && accept;
      end
      WR: begin
        if (!POSTED) begin
          if (wb_fail) state_next = ERR1;
          else if (wb_ack) state_next = IDLE;
        end else begin
          perr_set = wb_fail;
          if (wb_fail || wb_ack) begin
            if (pend_valid || accept) begin
              load_cur   = 1'b1;
              state_next = route(src_err, src_write);
            end else begin
              state_next = IDLE;
            end
          end else begin
            pend_set = accept;
          end
        end
      end
      ERR1:    state_next = ERR2;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    wb_we     = 1'b0;
    case (state)
      RD: begin
        HREADYOUT = 1'b0;
        wb_cyc    = !tmo;
        wb_stb    = !tmo;
      end
      WLAT: begin
        HREADYOUT = POSTED;
        wb_cyc    = hold_cyc;
      end
      WR: begin
        HREADYOUT = POSTED && !pend_valid;
        wb_cyc    = !tmo;
        wb_stb    = !tmo;
        wb_we     = 1'b1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2:    HRESP = 1'b1;
      default: HREADYOUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_wb_bridge.sv
// Directed self-checking bench for ahb_lite_wb_bridge (32-bit, posted writes,
// timeout of 4 cycles) with hand-computed expectations.
module tb_ahb_lite_wb_bridge;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic        posted_err, posted_err_clr;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  // Single AHB slave on the bus, so the shared ready is our own ready.
  assign hready = hreadyout;

  ahb_lite_wb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .POSTED_WRITES(1), .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK(clk), .HRESETn(hresetn),
    .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .posted_err_o(posted_err), .posted_err_clr_i(posted_err_clr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                               input logic wr, input logic [2:0] size);
    hsel   = sel;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
  endtask

  task automatic wbRespond(input logic ack, input logic err, input logic [31:0] dat);
    wb_ack   = ack;
    wb_err   = err;
    wb_dat_r = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    hresetn = 1'b0;
    hburst = 3'b000;
    hwdata = '0;
    posted_err_clr = 1'b0;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    wbRespond(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    settle();
    checkOutput("rst_hreadyout", hreadyout, 1);
    checkOutput("rst_hresp", hresp, 0);
    checkOutput("rst_hrdata", hrdata, 0);
    checkOutput("rst_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 0);
    checkOutput("rst_adr", wb_adr, 0);
    checkOutput("rst_sel", wb_sel, 0);
    checkOutput("rst_dat_w", wb_dat_w, 0);
    checkOutput("rst_posted_err", posted_err, 0);
    tick();
    hresetn = 1'b1;
    tick();

    $display("[TB] word read 0x100");
    applyStimulus(1'b1, 32'h100, 2'b10, 1'b0, 3'd2);
    settle();
    checkOutput("rd_addr_ready", hreadyout, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    wbRespond(1'b1, 1'b0, 32'hDEADBEEF);
    settle();
    checkOutput("rd_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b110);
    checkOutput("rd_sel", wb_sel, 4'hF);
    checkOutput("rd_adr", wb_adr, 32'h100);
    checkOutput("rd_wait", hreadyout, 0);
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rd_done_ready", hreadyout, 1);
    checkOutput("rd_data", hrdata, 32'hDEADBEEF);
    checkOutput("rd_done_cyc", wb_cyc, 0);
    tick();

    $display("[TB] halfword read 0x102");
    applyStimulus(1'b1, 32'h102, 2'b10, 1'b0, 3'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    wbRespond(1'b1, 1'b0, 32'h12345678);
    settle();
    checkOutput("hw_sel", wb_sel, 4'hC);
    checkOutput("hw_adr", wb_adr, 32'h100);
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("hw_data", hrdata, 32'h12345678);
    tick();

    $display("[TB] posted byte write 0x203");
    applyStimulus(1'b1, 32'h203, 2'b10, 1'b1, 3'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    hwdata = 32'hAB000000;
    settle();
    checkOutput("bw_zero_wait", hreadyout, 1);
    checkOutput("bw_wlat_stb", wb_stb, 0);
    tick();
    wbRespond(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("bw_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b111);
    checkOutput("bw_adr", wb_adr, 32'h200);
    checkOutput("bw_sel", wb_sel, 4'h8);
    checkOutput("bw_dat", wb_dat_w, 32'hAB000000);
    checkOutput("bw_wr_ready", hreadyout, 1);
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("bw_done_cyc", wb_cyc, 0);
    checkOutput("bw_no_perr", posted_err, 0);
    tick();

    $display("[TB] posted write 0x10 then read 0x20");
    applyStimulus(1'b1, 32'h10, 2'b10, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b1, 32'h20, 2'b10, 1'b0, 3'd2);
    hwdata = 32'h11223344;
    settle();
    checkOutput("pp_wlat_ready", hreadyout, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    hwdata = 32'h0;
    settle();
    checkOutput("pp_wr_hold", hreadyout, 0);
    checkOutput("pp_wr_stb_we", {wb_stb, wb_we}, 2'b11);
    checkOutput("pp_wr_adr", wb_adr, 32'h10);
    checkOutput("pp_wr_dat", wb_dat_w, 32'h11223344);
    tick();
    settle();
    checkOutput("pp_wr_hold2", hreadyout, 0);
    tick();
    wbRespond(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("pp_ack_hold", hreadyout, 0);
    checkOutput("pp_ack_cyc", wb_cyc, 1);
    tick();
    wbRespond(1'b1, 1'b0, 32'hCAFEF00D);
    settle();
    checkOutput("pp_rd_cyc_stb_we", {wb_cyc, wb_stb, wb_we}, 3'b110);
    checkOutput("pp_rd_adr", wb_adr, 32'h20);
    checkOutput("pp_rd_hold", hreadyout, 0);
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("pp_rd_ready", hreadyout, 1);
    checkOutput("pp_rd_data", hrdata, 32'hCAFEF00D);
    checkOutput("pp_rd_done_cyc", wb_cyc, 0);
    tick();

    $display("[TB] misaligned halfword 0x101");
    applyStimulus(1'b1, 32'h101, 2'b10, 1'b0, 3'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    settle();
    checkOutput("de_err1", {hresp, hreadyout, wb_cyc}, 3'b100);
    tick();
    settle();
    checkOutput("de_err2", {hresp, hreadyout, wb_cyc}, 3'b110);
    tick();
    settle();
    checkOutput("de_after", {hresp, hreadyout}, 2'b01);
    tick();

    $display("[TB] read timeout");
    applyStimulus(1'b1, 32'h40, 2'b10, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (!wb_stb) break;
      n++;
      tick();
    end
    checkOutput("to_stb_cycles", n, 4);
    checkOutput("to_drop", {wb_cyc, hresp, hreadyout}, 3'b000);
    tick();
    settle();
    checkOutput("to_err1", {hresp, hreadyout}, 2'b10);
    tick();
    settle();
    checkOutput("to_err2", {hresp, hreadyout}, 2'b11);
    tick();
    settle();
    checkOutput("to_after", {hresp, hreadyout}, 2'b01);
    tick();

    $display("[TB] posted write error");
    applyStimulus(1'b1, 32'h80, 2'b10, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    hwdata = 32'h1;
    tick();
    wbRespond(1'b0, 1'b1, 32'h0);
    settle();
    checkOutput("pe_no_ahb_err", {hresp, hreadyout}, 2'b01);
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("pe_flag_set", posted_err, 1);
    checkOutput("pe_cyc", wb_cyc, 0);
    tick();
    settle();
    checkOutput("pe_flag_sticky", posted_err, 1);
    posted_err_clr = 1'b1;
    tick();
    posted_err_clr = 1'b0;
    settle();
    checkOutput("pe_flag_clr", posted_err, 0);
    tick();

    $display("[TB] posted error with simultaneous clear");
    applyStimulus(1'b1, 32'h84, 2'b10, 1'b1, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    tick();
    wbRespond(1'b0, 1'b1, 32'h0);
    posted_err_clr = 1'b1;
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    posted_err_clr = 1'b0;
    settle();
    checkOutput("pe_set_wins", posted_err, 1);
    posted_err_clr = 1'b1;
    tick();
    posted_err_clr = 1'b0;
    tick();

    $display("[TB] reset during read");
    applyStimulus(1'b1, 32'h300, 2'b10, 1'b0, 3'd2);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    settle();
    checkOutput("rr_stb", wb_stb, 1);
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    settle();
    checkOutput("rr_drop", {wb_cyc, wb_stb, hreadyout}, 3'b001);
    wbRespond(1'b1, 1'b0, 32'h55555555);
    tick();
    wbRespond(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rr_late_ack", hrdata, 32'h0);
    checkOutput("rr_idle", {wb_cyc, hreadyout, hresp}, 3'b010);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_wb_bridge.md
# ahb_lite_wb_bridge

Parametrised AHB-Lite slave to Wishbone (classic, pipelined-strobe) master bridge. It connects one AHB master port of the core (instruction or data) to the Controller's Wishbone memory port. It generalises the fixed 32-bit adapter with the following additions:
- configurable data width;
- byte-lane selects derived from HSIZE/HADDR;
- optional posted writes;
- a Wishbone timeout;
- spec-compliant two-cycle AHB error responses.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width, AHB and Wishbone.
- DATA_WIDTH, 32: data width, 32 or 64; SEL_W = DATA_WIDTH/8, LSB = log2(SEL_W).
- POSTED_WRITES, 1: 1 = writes complete on AHB before the Wishbone ack.
- TIMEOUT_CYCLES, 255: max cycles stb may wait for ack/err; 0 disables the timeout.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
  - HCLK  in  1  clock.
  - HRESETn  in  1  synchronous active-low reset.
- AHB-Lite slave side:
  - HSEL  in  1  slave select.
  - HADDR  in  ADDR_WIDTH  address.
  - HTRANS  in  2  transfer type.
  - HWRITE  in  1  1 = write.
  - HSIZE  in  3  transfer size.
  - HBURST  in  3  ignored; each beat is converted individually.
  - HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
  - HREADY  in  1  bus ready, as seen by all slaves.
  - HREADYOUT  out  1  this slave ready.
  - HRDATA  out  DATA_WIDTH  registered read data.
  - HRESP  out  1  1 = ERROR.
- Wishbone master side:
  - wb_cyc  out  1.
  - wb_stb  out  1.
  - wb_we  out  1.
  - wb_adr  out  ADDR_WIDTH  address, low LSB bits zero.
  - wb_sel  out  SEL_W  byte-lane selects.
  - wb_dat_w  out  DATA_WIDTH.
  - wb_dat_r  in  DATA_WIDTH.
  - wb_ack  in  1.
  - wb_err  in  1.
- Posted-write error reporting:
  - posted_err_o  out  1  sticky flag: a posted write failed.
  - posted_err_clr_i  in  1  clears posted_err_o.

## Operation
Transfer acceptance:
- Accept = HSEL & HTRANS[1] & HREADY. NONSEQ and SEQ are treated identically.
- IDLE/BUSY, or HSEL=0, get a zero-wait OKAY response.
- On accept, latch HADDR, HWRITE and HSIZE.

Byte lanes and address:
- wb_sel = ((1<<(1<<HSIZE))-1) << HADDR[LSB-1:0].
- wb_adr = {HADDR[ADDR_WIDTH-1:LSB], LSB'b0}.

Decode error (no Wishbone cycle is issued):
- Raised when HSIZE > LSB, or HADDR is not aligned to 2^HSIZE.
- Response goes straight to ERR1.

FSM states: IDLE, RD, WLAT, WR, ERR1, ERR2.
- IDLE:
  - Read accepted: go to RD.
  - Write accepted: go to WLAT.
  - Decode error: go to ERR1.
- RD:
  - Drives cyc=stb=1, we=0, HREADYOUT=0.
  - On ack: HRDATA <= wb_dat_r, go to IDLE. HREADYOUT is 1 in the next cycle.
  - On err or timeout: go to ERR1.
- WLAT (data-phase cycle; HWDATA is sampled into wb_dat_w at its end):
  - POSTED_WRITES=1: HREADYOUT=1 in WLAT; go to WR with the posted flag set.
  - POSTED_WRITES=0: HREADYOUT=0; go to WR.
- WR:
  - Drives cyc=stb=we=1.
  - Non-posted: HREADYOUT=0 until ack, then IDLE (HREADYOUT=1 next cycle). err or timeout goes to ERR1.
  - Posted: err or timeout sets posted_err_o and returns to IDLE; no AHB error is given.
- ERR1: HRESP=1, HREADYOUT=0.
- ERR2: HRESP=1, HREADYOUT=1; then IDLE.

Pipelined transfers:
- A transfer accepted during posted WLAT or later (with HREADY=1) is held in a one-entry pending register.
- Its data phase shows HREADYOUT=0 until the posted write completes.
- It then starts without an idle gap: cyc stays high, and stb stays high when the next beat is a read.
- Only one posted write is ever outstanding.

Timeout:
- An 8..16-bit counter (width sized to TIMEOUT_CYCLES) clears on every new strobe and increments while stb=1 with no ack/err.
- When the counter equals TIMEOUT_CYCLES, cyc/stb drop that cycle and the transfer is treated as wb_err.

Flag and lane rules:
- posted_err_clr_i in the same cycle as a new posted error: the set wins.
- wb_ack and wb_err together: treated as err.
- HRDATA holds its last value outside a read completion.

## Timing
Reset (HRESETn=0 at a rising edge) sets, on the next cycle:
- HREADYOUT=1.
- HRESP=0, HRDATA=0.
- wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_sel=0, wb_dat_w=0.
- posted_err_o=0.
- FSM = IDLE, pending register cleared, timeout counter cleared.

Reset during an open Wishbone cycle drops cyc/stb on the next edge; a late ack is ignored.

Cycle numbering: address phase = cycle 0, ack arriving in cycle k (k ≥ 1 for reads, k ≥ 2 for writes).

Latencies:
- Read: stb is high from cycle 1; HREADYOUT=1 with data in cycle k+1. With zero-wait memory (k=1), that is 1 wait state.
- Non-posted write: stb is high from cycle 2; HREADYOUT=1 in cycle k+1.
- Posted write: HREADYOUT=1 in cycle 1 (zero wait); stb is high from cycle 2 until ack.
- Error: HRESP=1 in cycles e and e+1; HREADYOUT is 0 then 1.

Wishbone signals wb_adr, wb_sel, wb_we and wb_dat_w are stable while stb=1.

## Test plan
- Read HADDR=0x100, HSIZE=2, memory acks in cycle 1 with 0xDEADBEEF -> stb in cycle 1, wb_sel=0xF, HRDATA=0xDEADBEEF with HREADYOUT=1 in cycle 2.
- Byte write HADDR=0x203, HWDATA=0xAB000000, POSTED_WRITES=1 -> wb_adr=0x200, wb_sel=0x8, we=1; HREADYOUT=1 in cycle 1.
- Posted write to 0x10 followed back-to-back by a read of 0x20, write ack delayed 3 cycles -> read data phase holds HREADYOUT=0 until the write ack; read stb follows with cyc continuous; no lost beat.
- Halfword at HADDR=0x101 -> no wb_cyc; HRESP=1 for 2 cycles with HREADYOUT 0 then 1.
- Read with no ack, TIMEOUT_CYCLES=4 -> stb drops after 4 cycles; two-cycle ERROR response follows.
- Posted write answered by wb_err -> posted_err_o=1 stays set; pulse posted_err_clr_i -> 0 next cycle.
- Reset asserted mid-read with stb=1 -> cyc/stb=0 and HREADYOUT=1 next cycle; an ack arriving afterwards has no effect.
